pc_fetch_unit: RTL

//  Owns the program counter and the instruction-fetch handshake. Issues one IMEM read at a time,

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit_slot.sv | 56 +++++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, reset address and fetch FSM state encoding for the fetch unit.
package pc_fetch_unit_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_slot.sv
// One-entry valid/ready holding register for {instr, pc} handed to decode.
// Flush beats load; an unaccepted entry holds its data and valid.
module pc_fetch_unit_slot
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus single-outstanding IMEM fetch FSM feeding a one-entry decode slot.
// Redirects flush the slot and discard any in-flight wrong-path response.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_overwrite,
  input  logic [PC_W-1:0]    overwrite_data,
  input  logic               stall,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc_mux,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e    state_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] imem_addr_q;
  logic            imem_req_q;
  logic            halted_q;

  logic issue_ok;
  logic slot_load;
  logic slot_flush;

  always_comb begin
    slot_flush = (state_q != ST_HALTED) && (pc_overwrite || halt);
    slot_load  = (state_q == ST_WAIT) && imem_valid && !pc_overwrite && !halt;
    // Issue only when the slot will be empty by the time the response lands.
    issue_ok   = (state_q == ST_IDLE) && !pc_overwrite && !halt && !stall &&
                 (!instr_valid || instr_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      if (state_q != ST_HALTED) begin
        if (pc_overwrite) begin
          fetch_pc_q <= overwrite_data;
          // An outstanding read is now wrong-path: drop it when it returns.
          if (state_q != ST_IDLE) begin
            state_q <= imem_valid ? ST_IDLE : ST_DISCARD;
          end
        end else if (halt) begin
          halted_q <= 1'b1;
          state_q  <= ST_HALTED;
        end else if (issue_ok) begin
          imem_req_q  <= 1'b1;
          imem_addr_q <= fetch_pc_q;
          state_q     <= ST_WAIT;
        end else if (imem_valid && (state_q != ST_IDLE)) begin
          if (state_q == ST_WAIT) begin
            fetch_pc_q <= fetch_pc_q + PC_ONE;
          end
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign halted    = halted_q;

  pc_fetch_unit_slot #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (slot_load),
    .flush_i (slot_flush),
    .ready_i (instr_ready),
    .instr_i (imem_data),
    .pc_i    (fetch_pc_q),
    .valid_o (instr_valid),
    .instr_o (instr),
    .pc_o    (pc_mux)
  );

endmodule
